jstk2_poll_sequencer: RTL and testbench
=======================================

// Module: jstk2_poll_sequencer
// PURPOSE
//  Frame-level SPI sequencer for the PmodJSTK2.
//  - Polls the joystick at a fixed rate. Each poll is one 5-byte SPI mode-0 frame with the
//    mandatory SS setup time and inter-byte gaps.
//  - Unpacks the returned X/Y/button bytes and presents them as registered outputs with a
//    1-cycle valid strobe.
//  - Replaces the free-running divided-clock controller. Runs entirely on the system clock,
//    using clock enables only.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency
//  SCLK_HZ      1_000_000    SPI clock frequency; HALF = CLK_HZ/(2*SCLK_HZ), must be >=2
//  SS_SETUP_US  15           SS low -> first SCLK rising edge, in us
//  BYTE_GAP_US  10           last SCLK of byte n -> first SCLK of byte n+1, in us
//  POLL_HZ      100          frame start rate
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  enable      in   1   1 = polling allowed
//  miso        in   1   JSTK2 MISO; synchronised internally (2 flops)
//  mosi        out  1   JSTK2 MOSI
//  ss          out  1   JSTK2 slave select, active-low
//  sclk        out  1   JSTK2 SPI clock; idles low
//  led_rgb     in   24  {R,G,B} command payload; ignored unless JSTK2_LED_CMD_EN is defined
//  x_pos       out  10  last X sample: {byte1[1:0], byte0}
//  y_pos       out  10  last Y sample: {byte3[1:0], byte2}
//  btn         out  2   {trigger, stick} = byte4[1:0]
//  data_valid  out  1   1-cycle pulse when x_pos/y_pos/btn update
//  busy        out  1   1 from SS falling edge until SS rising edge
// BEHAVIOUR
//  - Reset (async, any time, including mid-frame):
//    - outputs: ss=1, sclk=0, mosi=0, x_pos=0, y_pos=0, btn=0, data_valid=0, busy=0.
//    - internal: FSM=IDLE, all counters=0, pending=0.
//  - Poll timer: free-running, period CLK_HZ/POLL_HZ cycles.
//    - Each wrap sets `pending`. `pending` is a single flag; a wrap while already pending is lost.
//  - FSM states: IDLE, SETUP, SHIFT, GAP, DONE.
//  - IDLE: ss=1, sclk=0. If pending && enable: clear pending, ss<=0, busy<=1, go to SETUP.
//  - SETUP: hold for SS_SETUP_US*CLK_HZ/1e6 cycles with ss=0, sclk=0. MOSI = bit7 of byte 0 valid. Then go to SHIFT.
//  - SHIFT: 8 bits, MSB first.
//    - Each bit = HALF cycles low followed by HALF cycles high.
//    - MISO sampled on the cycle sclk rises; MOSI changes only on sclk falling/low phase.
//    - After bit 0 high phase: sclk<=0; byte_idx<4 -> GAP, else DONE.
//  - GAP: hold ss=0, sclk=0 for BYTE_GAP_US*CLK_HZ/1e6 cycles. Load next tx byte. Go to SHIFT.
//  - DONE:
//    - ss<=1, busy<=0.
//    - Latch x_pos/y_pos/btn from the 5 rx bytes in one cycle; data_valid=1 for exactly that cycle.
//    - Go to IDLE.
//  - Outputs hold their value between frames. A partial frame never updates outputs.
//  - enable deasserted mid-frame: current frame completes and updates normally; no new frame starts.
//  - `pending` set in the same cycle as DONE: next frame starts from IDLE on the following cycle.
//  - Counter widths: $clog2 of the respective max count + 1. No wrap inside a phase.
// CONFIGURATION
//  JSTK2_LED_CMD_EN defined:
//    - tx bytes = 8'h84, R, G, B, 8'h00.
//    - led_rgb is sampled in IDLE when the frame starts and held for the whole frame.
//  JSTK2_LED_CMD_EN undefined:
//    - all tx bytes = 8'h00; mosi is constant 0 and led_rgb is unused.
//    - RX path identical.
// STRUCTURE
//  - Package jstk2_pkg:
//    - state_t enum {IDLE,SETUP,SHIFT,GAP,DONE}
//    - CMD_SET_LED = 8'h84, CMD_NOP = 8'h00, FRAME_BYTES = 5
//    - function us_to_cycles(clk_hz, us)
//  - Sub-module jstk2_byte_shifter: one SPI mode-0 byte.
//    - Inputs: start, tx_byte, miso_s. Outputs: sclk, mosi, rx_byte, done.
//    - Parameter HALF.
//    - Owns the half-period and bit counters.
//  - Top: poll timer, FSM, setup/gap counter, byte index, rx byte store, output regs.
// TESTING (CLK_HZ=100e6, SCLK_HZ=1e6, POLL_HZ=1000 for sim)
//  1. Reset, enable=1, model returns 0x34,0x02,0xC8,0x01,0x82.
//     -> x_pos=0x234, y_pos=0x1C8, btn=2'b10; one data_valid pulse per frame; frames 100_000 cycles apart.
//  2. Timing checks: ss fall -> first sclk rise = 1500+50 cycles; sclk high/low = 50/50 cycles;
//     8 rises per byte, 40 per frame; byte gap >=1000 cycles; sclk=0 whenever ss=1.
//  3. With JSTK2_LED_CMD_EN and led_rgb=24'hFF8001: MOSI bytes = 84,FF,80,01,00.
//     Without the macro: mosi=0 for the whole run.
//  4. Drop enable during byte 2: frame finishes and updates outputs; no further ss fall
//     while enable=0; polling resumes on the next pending tick after enable=1.
//  5. Assert rst during SHIFT of byte 3:
//     -> same cycle ss=1, sclk=0, busy=0; outputs=0; no data_valid.
//     After release: first frame starts only after the next poll wrap.
//  6. Force poll wrap during a frame: exactly one queued frame starts one cycle after the DONE state; no double frames.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared types and constants for the PmodJSTK2 poll sequencer.
package jstk2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'h84;
  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam int         FRAME_BYTES = 5;

  // Whole system-clock cycles in a microsecond interval, rounded down.
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return int'(longint'(clk_hz) * longint'(us) / longint'(1_000_000));
  endfunction

endpackage

// File: rtl/jstk2_byte_shifter.sv
// One SPI mode-0 byte, MSB first: HALF cycles sclk low, then HALF cycles high, per bit.
module jstk2_byte_shifter
  import jstk2_pkg::*;
#(
  parameter int HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso_s,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);
  localparam int HW = $clog2(HALF) + 1;

  logic [HW-1:0] r_half_cnt;
  logic [3:0]    r_bit_cnt;
  logic          r_active;
  logic          r_sclk;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          w_half_end;

  assign w_half_end = (r_half_cnt == HW'(HALF - 1));
  // done is combinational so the caller moves on in the same cycle sclk falls.
  assign done    = r_active & r_sclk & w_half_end & (r_bit_cnt == 4'd7);
  assign sclk    = r_sclk;
  // Before the first bit the caller's byte is shown directly, so bit 7 is valid during setup/gap.
  assign mosi    = r_active ? r_tx[7] : tx_byte[7];
  assign rx_byte = r_rx;

  // NOTE: sequential state is written only with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_active   <= 1'b0;
      r_sclk     <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
    end else if (start) begin
      r_active   <= 1'b1;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_tx       <= tx_byte;
    end else if (r_active) begin
      if (w_half_end) begin
        r_half_cnt <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], miso_s};
        end else begin
          r_sclk <= 1'b0;
          r_tx   <= {r_tx[6:0], 1'b0};
          if (r_bit_cnt == 4'd7) r_active  <= 1'b0;
          else                   r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_half_cnt <= r_half_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/jstk2_poll_sequencer.sv
// Periodic 5-byte SPI poll of a PmodJSTK2 on the system clock (clock enables only).
// Define JSTK2_LED_CMD_EN to send SET_LED with led_rgb; otherwise every tx byte is NOP.
module jstk2_poll_sequencer
  import jstk2_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCLK_HZ     = 1_000_000,
  parameter int SS_SETUP_US = 15,
  parameter int BYTE_GAP_US = 10,
  parameter int POLL_HZ     = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        miso,
  output logic        mosi,
  output logic        ss,
  output logic        sclk,
  input  logic [23:0] led_rgb,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  btn,
  output logic        data_valid,
  output logic        busy
);
  localparam int HALF      = CLK_HZ / (2 * SCLK_HZ);
  localparam int SETUP_CYC = us_to_cycles(CLK_HZ, SS_SETUP_US);
  localparam int GAP_CYC   = us_to_cycles(CLK_HZ, BYTE_GAP_US);
  localparam int POLL_CYC  = CLK_HZ / POLL_HZ;
  localparam int DLY_MAX   = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int PW        = $clog2(POLL_CYC) + 1;
  localparam int DW        = $clog2(DLY_MAX) + 1;
  localparam int BW        = $clog2(FRAME_BYTES - 1) + 1;

  state_t        r_state;
  logic [PW-1:0] r_poll_cnt;
  logic          r_pending;
  logic [DW-1:0] r_dly_cnt;
  logic [BW-1:0] r_byte_idx;
  logic          r_miso_meta;
  logic          r_miso_s;
  logic          r_ss;
  logic          r_busy;
  logic          r_valid;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [1:0]    r_btn;
  logic [7:0]    r_rx_bytes [FRAME_BYTES];

  logic       w_poll_wrap;
  logic       w_start_frame;
  logic       w_shift_start;
  logic [7:0] w_tx_byte;
  logic       w_sclk;
  logic       w_mosi;
  logic [7:0] w_rx_byte;
  logic       w_byte_done;

  assign w_poll_wrap   = (r_poll_cnt == PW'(POLL_CYC - 1));
  assign w_start_frame = (r_state == IDLE) && r_pending && enable;
  assign w_shift_start = ((r_state == SETUP) && (r_dly_cnt == DW'(SETUP_CYC - 1))) ||
                         ((r_state == GAP)   && (r_dly_cnt == DW'(GAP_CYC - 1)));

`ifdef JSTK2_LED_CMD_EN
  logic [23:0] r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_led <= '0;
    else if (w_start_frame) r_led <= led_rgb;
  end

  always_comb begin
    w_tx_byte = CMD_NOP;
    case (r_byte_idx)
      BW'(0): w_tx_byte = CMD_SET_LED;
      BW'(1): w_tx_byte = r_led[23:16];
      BW'(2): w_tx_byte = r_led[15:8];
      BW'(3): w_tx_byte = r_led[7:0];
      default: w_tx_byte = CMD_NOP;
    endcase
  end
`else
  logic w_unused_led;
  assign w_unused_led = ^led_rgb;
  assign w_tx_byte    = CMD_NOP;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miso_meta <= 1'b0;
      r_miso_s    <= 1'b0;
    end else begin
      r_miso_meta <= miso;
      r_miso_s    <= r_miso_meta;
    end
  end

  // A wrap while a frame is already pending is simply absorbed by the single flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + PW'(1);
      if (w_start_frame) r_pending <= 1'b0;
      if (w_poll_wrap)   r_pending <= 1'b1;
    end
  end

  jstk2_byte_shifter #(
    .HALF (HALF)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (w_shift_start),
    .tx_byte (w_tx_byte),
    .miso_s  (r_miso_s),
    .sclk    (w_sclk),
    .mosi    (w_mosi),
    .rx_byte (w_rx_byte),
    .done    (w_byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_dly_cnt  <= '0;
      r_byte_idx <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_btn      <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_frame) begin
            r_ss       <= 1'b0;
            r_busy     <= 1'b1;
            r_dly_cnt  <= '0;
            r_byte_idx <= '0;
            r_state    <= SETUP;
          end
        end
        SETUP, GAP: begin
          if (w_shift_start) begin
            r_dly_cnt <= '0;
            r_state   <= SHIFT;
          end else begin
            r_dly_cnt <= r_dly_cnt + DW'(1);
          end
        end
        SHIFT: begin
          if (w_byte_done) begin
            if (r_byte_idx == BW'(FRAME_BYTES - 1)) begin
              r_state <= DONE;
            end else begin
              r_byte_idx <= r_byte_idx + BW'(1);
              r_state    <= GAP;
            end
          end
        end
        DONE: begin
          r_ss       <= 1'b1;
          r_busy     <= 1'b0;
          r_valid    <= 1'b1;
          r_x        <= {r_rx_bytes[1][1:0], r_rx_bytes[0]};
          r_y        <= {r_rx_bytes[3][1:0], r_rx_bytes[2]};
          r_btn      <= r_rx_bytes[4][1:0];
          r_byte_idx <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the rx byte store has no reset; it is fully rewritten before DONE reads it,
  // so a reset would only cost routing.
  always_ff @(posedge clk) begin
    if ((r_state == SHIFT) && w_byte_done) r_rx_bytes[r_byte_idx] <= w_rx_byte;
  end

  logic w_unused_rx;
  assign w_unused_rx = ^{r_rx_bytes[1][7:2], r_rx_bytes[3][7:2], r_rx_bytes[4][7:2]};

  assign ss         = r_ss;
  assign sclk       = w_sclk;
  assign mosi       = r_busy & w_mosi;
  assign busy       = r_busy;
  assign data_valid = r_valid;
  assign x_pos      = r_x;
  assign y_pos      = r_y;
  assign btn        = r_btn;

endmodule

// File: tb/tb_jstk2_poll_sequencer.sv
// Self-checking bench for jstk2_poll_sequencer: SPI slave model plus a frame-level reference model.
module tb_jstk2_poll_sequencer;

  localparam int CLK_HZ      = 10_000_000;
  localparam int SCLK_HZ     = 1_000_000;
  localparam int SS_SETUP_US = 15;
  localparam int BYTE_GAP_US = 10;
  localparam int POLL_HZ     = 4000;

  localparam int HALF  = CLK_HZ / (2 * SCLK_HZ);
  localparam int SETUP = SS_SETUP_US * (CLK_HZ / 1_000_000);
  localparam int GAP   = BYTE_GAP_US * (CLK_HZ / 1_000_000);
  localparam int P     = CLK_HZ / POLL_HZ;
  // ss low span: setup, five 8-bit bytes, four gaps, then the DONE cycle.
  localparam int L     = SETUP + 5 * 16 * HALF + 4 * GAP + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        miso;
  logic        mosi;
  logic        ss;
  logic        sclk;
  logic [23:0] led_rgb;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [1:0]  btn;
  logic        data_valid;
  logic        busy;

  jstk2_poll_sequencer #(
    .CLK_HZ      (CLK_HZ),
    .SCLK_HZ     (SCLK_HZ),
    .SS_SETUP_US (SS_SETUP_US),
    .BYTE_GAP_US (BYTE_GAP_US),
    .POLL_HZ     (POLL_HZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .miso       (miso),
    .mosi       (mosi),
    .ss         (ss),
    .sclk       (sclk),
    .led_rgb    (led_rgb),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .btn        (btn),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference-model and monitor state
  int          n;
  bit          m_pending, m_busy;
  int          m_start, m_idle_from;
  logic [23:0] m_led;
  logic [9:0]  m_x, m_y;
  logic [1:0]  m_btn;
  logic [7:0]  sb [5];
  int          pos, rises, frames, f_start, last_rise, last_fall, ss_rise_n, fall_gap;
  int          sclk_viol, busy_viol, mosi_viol;
  bit          first_frame;

  function automatic logic [7:0] tx_exp(input int i);
`ifdef JSTK2_LED_CMD_EN
    case (i)
      0: return 8'h84;
      1: return m_led[23:16];
      2: return m_led[15:8];
      3: return m_led[7:0];
      default: return 8'h00;
    endcase
`else
    return (i >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  initial begin : monitor
    bit          en_s, rst_s, exp_start, exp_rise, ss_fall, ss_rise, sc_rise, sc_fall, prev_ss, prev_sclk;
    logic [23:0] led_s;
    logic [7:0]  mbyte;
    n = 0; m_pending = 0; m_busy = 0; m_idle_from = 0; m_led = '0;
    m_x = '0; m_y = '0; m_btn = '0; pos = 0; rises = 0; frames = 0;
    f_start = 0; last_rise = 0; last_fall = 0; ss_rise_n = 0; fall_gap = 0;
    sclk_viol = 0; busy_viol = 0; mosi_viol = 0; first_frame = 1;
    prev_ss = 1; prev_sclk = 0; mbyte = '0; miso = 1'b0;
    forever begin
      @(posedge clk);
      en_s  = enable;
      led_s = led_rgb;
      rst_s = rst;
      #1;
      if (rst_s || rst) begin
        n = 0; m_pending = 0; m_busy = 0; m_idle_from = 0;
        m_x = '0; m_y = '0; m_btn = '0;
        prev_ss = 1; prev_sclk = 0; rises = 0; miso = 1'b0;
        continue;
      end
      n++;
      // Frame-level model: poll wraps every P edges into a one-deep pending flag;
      // a frame holds ss low for L edges and the next may start one edge after ss rises.
      exp_start = 0;
      exp_rise  = 0;
      if (!m_busy && n >= m_idle_from && m_pending && en_s) begin
        exp_start = 1; m_pending = 0; m_busy = 1; m_start = n; m_led = led_s;
      end
      if (n % P == 0) m_pending = 1;
      if (m_busy && n == m_start + L) begin
        exp_rise = 1; m_busy = 0; m_idle_from = n + 1;
      end

      ss_fall = prev_ss && !ss;
      ss_rise = !prev_ss && ss;
      sc_rise = !prev_sclk && sclk;
      sc_fall = prev_sclk && !sclk;
      if (ss && sclk) sclk_viol++;
      if (busy !== !ss) busy_viol++;
`ifndef JSTK2_LED_CMD_EN
      if (mosi !== 1'b0) mosi_viol++;
`endif

      if (exp_start || ss_fall) check("ss_fall", 32'(ss_fall), 32'(exp_start));
      if (exp_rise || ss_rise)  check("ss_rise", 32'(ss_rise), 32'(exp_rise));

      if (ss_fall) begin
        check("hold_x", 32'(x_pos), 32'(m_x));
        check("hold_y", 32'(y_pos), 32'(m_y));
        check("hold_btn", 32'(btn), 32'(m_btn));
        check("sclk_idle", sclk_viol, 0);
        check("busy_track", busy_viol, 0);
        fall_gap = n - ss_rise_n;
        f_start  = n;
        rises    = 0;
        pos      = 0;
        if (first_frame) begin
          sb[0] = 8'h34; sb[1] = 8'h02; sb[2] = 8'hC8; sb[3] = 8'h01; sb[4] = 8'h82;
          first_frame = 0;
        end else begin
          for (int i = 0; i < 5; i++) sb[i] = 8'($urandom);
        end
        miso = sb[0][7];
      end

      if (sc_rise) begin
        rises++;
        if (rises == 1)              check("setup_time", n - f_start, SETUP + HALF);
        else if ((rises - 1) % 8 == 0) check("byte_gap", 32'((n - last_fall) >= GAP), 1);
        else                          check("sclk_low", n - last_fall, HALF);
        last_rise = n;
        mbyte = {mbyte[6:0], mosi};
        if (rises % 8 == 0) check("mosi_byte", 32'(mbyte), 32'(tx_exp(rises / 8 - 1)));
      end

      if (sc_fall) begin
        check("sclk_high", n - last_rise, HALF);
        last_fall = n;
        if (pos < 39) pos++;
        miso = sb[pos / 8][7 - (pos % 8)];
      end

      if (data_valid || ss_rise) check("dv_align", 32'(data_valid), 32'(ss_rise));

      if (ss_rise) begin
        check("rises_per_frame", rises, 40);
        m_x   = {sb[1][1:0], sb[0]};
        m_y   = {sb[3][1:0], sb[2]};
        m_btn = sb[4][1:0];
        check("x_pos", 32'(x_pos), 32'(m_x));
        check("y_pos", 32'(y_pos), 32'(m_y));
        check("btn", 32'(btn), 32'(m_btn));
        ss_rise_n = n;
        frames++;
      end

      prev_ss   = ss;
      prev_sclk = sclk;
    end
  end

  task automatic wait_frames(input int k, input int budget);
    int target;
    int c;
    target = frames + k;
    c = 0;
    while (frames < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_frames_timeout", 32'(frames >= target), 1);
  endtask

  // Wait for the start of a new frame, then until it has produced min_rises sclk rises.
  task automatic wait_in_frame(input int min_rises);
    int c;
    c = 0;
    while (!ss && c < 2 * P) begin
      @(negedge clk);
      c++;
    end
    while (!(!ss && rises >= min_rises) && c < 4 * P) begin
      @(negedge clk);
      c++;
    end
    check("wait_in_frame_timeout", 32'(!ss && rises >= min_rises), 1);
  endtask

  initial begin : stim
    int c;
    rst     = 1'b1;
    enable  = 1'b1;
    led_rgb = 24'hFF8001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", 32'(ss), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_x", 32'(x_pos), 0);
    check("rst_y", 32'(y_pos), 0);
    check("rst_btn", 32'(btn), 0);
    check("rst_dv", 32'(data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed first frame, then free polling
    wait_frames(1, 2 * P);
    check("t1_x", 32'(x_pos), 32'h234);
    check("t1_y", 32'(y_pos), 32'h1C8);
    check("t1_btn", 32'(btn), 32'h2);
    wait_frames(2, 3 * P);

    // Drop enable during byte 2: frame completes, then silence
    wait_in_frame(20);
    @(negedge clk);
    enable = 1'b0;
    wait_frames(1, P);
    repeat (3 * P) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_ss", 32'(ss), 1);

    // Re-enable 400 cycles before a wrap: held pending starts a frame, the wrap queues one more
    c = 0;
    while ((n % P) != (P - 400) && c < 2 * P) begin
      @(negedge clk);
      c++;
    end
    enable = 1'b1;
    wait_frames(2, 2 * P);
    check("b2b_start_gap", fall_gap, 1);
    repeat (P) @(negedge clk);

    // Randomised enable windows and LED payloads
    for (int k = 0; k < 6; k++) begin
      enable  = ($urandom_range(0, 3) != 0);
      led_rgb = 24'($urandom);
      repeat ($urandom_range(200, 2000)) @(negedge clk);
    end
    enable = 1'b1;

    // Reset during byte 3
    wait_in_frame(27);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ss", 32'(ss), 1);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_x", 32'(x_pos), 0);
    check("mid_rst_y", 32'(y_pos), 0);
    check("mid_rst_btn", 32'(btn), 0);
    check("mid_rst_dv", 32'(data_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (ss && c < 2 * P) begin
      @(negedge clk);
      c++;
    end
    check("post_rst_first_start", c, P + 1);
    wait_frames(1, 2 * P);

    check("sclk_idle_final", sclk_viol, 0);
    check("busy_track_final", busy_viol, 0);
`ifndef JSTK2_LED_CMD_EN
    check("mosi_zero", mosi_viol, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
